// File: rtl/data_memory.sv
// data_memory: byte-wide data memory for the 9-bit core.
// The core port is a zero-latency read / edge-write port driven by the control
// unit. A 4-phase req/ack host port lets a loader or bench preload and dump the
// array. A host access steals exactly one cycle (BUSY), during which the core
// is stalled. The core always has priority when starting a host access.
// Optional feature macro: DATA_MEMORY_STATS_EN adds saturating counters
// rd_count/wr_count of accepted core reads and writes.
module data_memory #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_mem_write,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_in,
    output logic [DATA_W-1:0] mem_out,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata
`ifdef DATA_MEMORY_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Storage array; deliberately not reset so preloaded contents survive.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // Host request captured on the IDLE -> BUSY transition.
    logic              r_lat_we;
    logic [ADDR_W-1:0] r_lat_addr;
    logic [DATA_W-1:0] r_lat_wdata;

    logic              r_core_stall;
    logic              r_host_ack;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_core_busy;
    logic              w_core_rd_acc;
    logic              w_core_wr_acc;
    logic              w_host_wr_fire;
    logic              w_host_rd_fire;
    logic              w_start_host;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Any core strobe blocks the start of a host access.
    assign w_core_busy    = ctrl_mem_read | ctrl_mem_write;

    // Core accesses are accepted only when the host does not own the array.
    assign w_core_rd_acc  = ctrl_mem_read  & ~r_core_stall;
    assign w_core_wr_acc  = ctrl_mem_write & ~r_core_stall;

    // Host operation happens at the edge that ends BUSY; reset cancels a write.
    assign w_host_wr_fire = (r_state == ST_BUSY) & r_lat_we & ~reset;
    assign w_host_rd_fire = (r_state == ST_BUSY) & ~r_lat_we;

    assign w_start_host   = (r_state == ST_IDLE) & (w_state_nxt == ST_BUSY);

    // Next-state logic of the host-arbitration FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (host_req && !w_core_busy) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (!host_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus stall/ack outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_core_stall <= 1'b0;
            r_host_ack   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_stall <= (w_state_nxt == ST_BUSY);
            r_host_ack   <= (w_state_nxt == ST_ACK);
        end
    end

    // Capture the host command when the FSM grants the host.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat_we    <= 1'b0;
            r_lat_addr  <= {ADDR_W{1'b0}};
            r_lat_wdata <= {DATA_W{1'b0}};
        end else if (w_start_host) begin
            r_lat_we    <= host_we;
            r_lat_addr  <= host_addr;
            r_lat_wdata <= host_wdata;
        end else begin
            r_lat_we    <= r_lat_we;
            r_lat_addr  <= r_lat_addr;
            r_lat_wdata <= r_lat_wdata;
        end
    end

    // Host read data register; holds until the next host read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_rdata <= {DATA_W{1'b0}};
        end else if (w_host_rd_fire) begin
            r_host_rdata <= r_mem[r_lat_addr];
        end else begin
            r_host_rdata <= r_host_rdata;
        end
    end

    // Single write port: host and core writes never coincide because the
    // core is stalled during BUSY, so the host simply takes precedence.
    always_comb begin
        w_mem_we    = w_host_wr_fire | w_core_wr_acc;
        w_mem_waddr = mem_addr_in;
        w_mem_wdata = mem_in;
        if (w_host_wr_fire) begin
            w_mem_waddr = r_lat_addr;
            w_mem_wdata = r_lat_wdata;
        end else begin
            w_mem_waddr = mem_addr_in;
            w_mem_wdata = mem_in;
        end
    end

    // Array write; a same-cycle read still observes the pre-edge contents.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Zero-latency core read; suppressed while stalled or when writing.
    always_comb begin
        if (w_core_rd_acc && !ctrl_mem_write) begin
            mem_out = r_mem[mem_addr_in];
        end else begin
            mem_out = {DATA_W{1'b0}};
        end
    end

    assign core_stall = r_core_stall;
    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;

`ifdef DATA_MEMORY_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    // Saturating counters of accepted core accesses; host traffic excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else begin
            if (w_core_rd_acc && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end else begin
                r_rd_count <= r_rd_count;
            end
            if (w_core_wr_acc && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end else begin
                r_wr_count <= r_wr_count;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units
// after the edge, well away from the active edge.
`timescale 1ns/1ps
module tb_data_memory;

    logic       clk;
    logic       reset;
    logic       ctrl_mem_read;
    logic       ctrl_mem_write;
    logic [7:0] mem_addr_in;
    logic [7:0] mem_in;
    logic [7:0] mem_out;
    logic       core_stall;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
`ifdef DATA_MEMORY_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int n_checks;
    int n_errors;

    data_memory #(.ADDR_W(8), .DATA_W(8)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_mem_read  (ctrl_mem_read),
        .ctrl_mem_write (ctrl_mem_write),
        .mem_addr_in    (mem_addr_in),
        .mem_in         (mem_in),
        .mem_out        (mem_out),
        .core_stall     (core_stall),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .host_rdata     (host_rdata)
`ifdef DATA_MEMORY_STATS_EN
        ,
        .rd_count       (rd_count),
        .wr_count       (wr_count)
`endif
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One core cycle: drive strobes, check mem_out, take the edge, release.
    task automatic core_cycle(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] data, input logic [7:0] exp_out, input string tag);
        ctrl_mem_read  = rd;
        ctrl_mem_write = wr;
        mem_addr_in    = addr;
        mem_in         = data;
        #1;
        check_value(tag, {8'h00, mem_out}, {8'h00, exp_out});
        tick();
        ctrl_mem_read  = 1'b0;
        ctrl_mem_write = 1'b0;
    endtask

    // Wait for host_ack with a cycle bound; expiry is a failed check.
    task automatic wait_ack(input int max_cycles);
        for (int i = 0; i < max_cycles && !host_ack; i++) begin
            tick();
        end
        check_value("ack_wait", {15'd0, host_ack}, 16'd1);
    endtask

    task automatic host_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        wait_ack(6);
        host_req = 1'b0;
        tick();
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        ctrl_mem_read  = 1'b0;
        ctrl_mem_write = 1'b0;
        mem_addr_in    = 8'h00;
        mem_in         = 8'h00;
        host_req       = 1'b0;
        host_we        = 1'b0;
        host_addr      = 8'h00;
        host_wdata     = 8'h00;

        // Reset state.
        tick();
        tick();
        #1;
        check_value("rst_ack",   {15'd0, host_ack},   16'd0);
        check_value("rst_stall", {15'd0, core_stall}, 16'd0);
        check_value("rst_rdata", {8'h00, host_rdata}, 16'h0000);
        check_value("rst_mem_out", {8'h00, mem_out},  16'h0000);
        reset = 1'b0;
        tick();

        // Host write 0x3C -> 0x10, ack two cycles after req.
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
        #1;
        check_value("hw_idle_stall", {15'd0, core_stall}, 16'd0);
        tick();
        #1;
        check_value("hw_busy_stall", {15'd0, core_stall}, 16'd1);
        check_value("hw_busy_ack",   {15'd0, host_ack},   16'd0);
        tick();
        #1;
        check_value("hw_ack",        {15'd0, host_ack},   16'd1);
        check_value("hw_ack_stall",  {15'd0, core_stall}, 16'd0);
        host_req = 1'b0;
        tick();
        #1;
        check_value("hw_ack_drop",   {15'd0, host_ack},   16'd0);
        core_cycle(1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, "core_rd_10");

        // Core SW then LW; write cycle itself shows 0 on mem_out.
        core_cycle(1'b0, 1'b1, 8'h20, 8'hA5, 8'h00, "core_wr_20");
        core_cycle(1'b1, 1'b0, 8'h20, 8'h00, 8'hA5, "core_rd_20");
        // Both strobes: write performed, mem_out forced to 0.
        core_cycle(1'b1, 1'b1, 8'h21, 8'hB7, 8'h00, "both_strobes_out");
        core_cycle(1'b1, 1'b0, 8'h21, 8'h00, 8'hB7, "both_strobes_wr");

        // Preload 0x05, 0xFF, 0x40 from the core.
        core_cycle(1'b0, 1'b1, 8'h05, 8'h11, 8'h00, "pre_05");
        core_cycle(1'b0, 1'b1, 8'hFF, 8'h5A, 8'h00, "pre_ff");
        core_cycle(1'b0, 1'b1, 8'h40, 8'h77, 8'h00, "pre_40");

        // Core strobe held with host_req pending: host must wait.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'hFF;
        ctrl_mem_read = 1'b1; mem_addr_in = 8'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check_value("prio_stall", {15'd0, core_stall}, 16'd0);
            check_value("prio_ack",   {15'd0, host_ack},   16'd0);
            check_value("prio_mem_out", {8'h00, mem_out},  16'h003C);
        end
        ctrl_mem_read = 1'b0;
        tick();
        // BUSY: core write to 0x05 must be ignored.
        ctrl_mem_write = 1'b1; mem_addr_in = 8'h05; mem_in = 8'hEE;
        #1;
        check_value("busy_stall",   {15'd0, core_stall}, 16'd1);
        check_value("busy_mem_out", {8'h00, mem_out},    16'h0000);
        tick();
        ctrl_mem_write = 1'b0;
        #1;
        check_value("hr_ff_ack",   {15'd0, host_ack},   16'd1);
        check_value("hr_ff_rdata", {8'h00, host_rdata}, 16'h005A);
        host_req = 1'b0;
        tick();
        #1;
        check_value("hr_ff_ack_drop", {15'd0, host_ack},   16'd0);
        check_value("hr_ff_hold",     {8'h00, host_rdata}, 16'h005A);
        core_cycle(1'b1, 1'b0, 8'h05, 8'h00, 8'h11, "busy_wr_ignored");

        // Host drops req during BUSY: still completes with a 1-cycle ack.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick();
        host_req = 1'b0;
        tick();
        #1;
        check_value("pulse_ack",   {15'd0, host_ack},   16'd1);
        check_value("pulse_rdata", {8'h00, host_rdata}, 16'h003C);
        tick();
        #1;
        check_value("pulse_ack_end", {15'd0, host_ack}, 16'd0);

        // Address extremes do not alias.
        host_access(1'b1, 8'h00, 8'hC3);
        core_cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'hC3, "addr_00");
        core_cycle(1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, "addr_ff");

        // Reset during BUSY of a host write to 0x40 discards the write.
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h99;
        tick();
        #1;
        check_value("rb_busy_stall", {15'd0, core_stall}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        host_req = 1'b0;
        #1;
        check_value("rb_ack",   {15'd0, host_ack},   16'd0);
        check_value("rb_stall", {15'd0, core_stall}, 16'd0);
        tick();
        #1;
        check_value("rb_ack_next", {15'd0, host_ack}, 16'd0);
        core_cycle(1'b1, 1'b0, 8'h40, 8'h00, 8'h77, "rb_mem_40");

`ifdef DATA_MEMORY_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_value("st_rst_rd", rd_count, 16'd0);
        check_value("st_rst_wr", wr_count, 16'd0);
        core_cycle(1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, "st_rd1");
        core_cycle(1'b1, 1'b0, 8'h20, 8'h00, 8'hA5, "st_rd2");
        core_cycle(1'b0, 1'b1, 8'h30, 8'h01, 8'h00, "st_wr1");
        core_cycle(1'b1, 1'b0, 8'h30, 8'h00, 8'h01, "st_rd3");
        core_cycle(1'b0, 1'b1, 8'h31, 8'h02, 8'h00, "st_wr2");
        host_access(1'b1, 8'h32, 8'h03);
        #1;
        check_value("st_rd_count", rd_count, 16'd3);
        check_value("st_wr_count", wr_count, 16'd2);
        ctrl_mem_write = 1'b1; mem_addr_in = 8'h33; mem_in = 8'h04;
        for (int i = 0; i < 65533; i++) begin
            tick();
        end
        #1;
        check_value("st_wr_full", wr_count, 16'hFFFF);
        tick();
        tick();
        ctrl_mem_write = 1'b0;
        #1;
        check_value("st_wr_sat", wr_count, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
